// File: rtl/onewire_slave_tx.sv
// onewire_slave_tx: transmit side of an emulated 1-Wire slave.
// Drives the open-drain DQ enable for presence pulses and read-slot "0" bits.
// Bytes are shifted out LSB first.
// Optional build macro ONEWIRE_TX_OVERDRIVE_EN adds od_mode and the overdrive timing set.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | DQ released, ready to accept a byte
// PRES_WAIT | high wait between presence request and presence low
// PRES_LOW  | presence pulse, DQ pulled low
// ARMED     | byte held, waiting for the master falling edge of a slot
// BIT_SLOT  | timing one read slot (DQ low for a "0", released for a "1")
module onewire_slave_tx #(
   parameter int PDH_CYC    = 30,
   parameter int PDL_CYC    = 120,
   parameter int BIT0_CYC   = 30
`ifdef ONEWIRE_TX_OVERDRIVE_EN
   ,
   parameter int OD_PDH_CYC  = 3,
   parameter int OD_PDL_CYC  = 10,
   parameter int OD_BIT0_CYC = 3
`endif
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       slot_start,
   input  logic       presence_req,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
`ifdef ONEWIRE_TX_OVERDRIVE_EN
   input  logic       od_mode,
`endif
   output logic       tx_ready,
   output logic       dq_oe,
   output logic       busy,
   output logic       byte_done,
   output logic       tx_abort
);

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int STD_MAX = max_i(PDH_CYC, max_i(PDL_CYC, BIT0_CYC));
`ifdef ONEWIRE_TX_OVERDRIVE_EN
   localparam int ALL_MAX = max_i(STD_MAX, max_i(OD_PDH_CYC, max_i(OD_PDL_CYC, OD_BIT0_CYC)));
`else
   localparam int ALL_MAX = STD_MAX;
`endif
   localparam int CW = $clog2(ALL_MAX) + 1;

   localparam logic [CW-1:0] PDH_LD  = CW'(PDH_CYC - 1);
   localparam logic [CW-1:0] PDL_LD  = CW'(PDL_CYC - 1);
   localparam logic [CW-1:0] BIT0_LD = CW'(BIT0_CYC - 1);
`ifdef ONEWIRE_TX_OVERDRIVE_EN
   localparam logic [CW-1:0] OD_PDH_LD  = CW'(OD_PDH_CYC - 1);
   localparam logic [CW-1:0] OD_PDL_LD  = CW'(OD_PDL_CYC - 1);
   localparam logic [CW-1:0] OD_BIT0_LD = CW'(OD_BIT0_CYC - 1);
`else
   localparam logic [CW-1:0] OD_PDH_LD  = PDH_LD;
   localparam logic [CW-1:0] OD_PDL_LD  = PDL_LD;
   localparam logic [CW-1:0] OD_BIT0_LD = BIT0_LD;
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRES_WAIT = 3'd1,
      PRES_LOW  = 3'd2,
      ARMED     = 3'd3,
      BIT_SLOT  = 3'd4
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic [2:0]      r_bitcnt, w_bitcnt_nxt;
   logic            r_dq_oe, w_dq_nxt;
   logic            r_byte_done, w_done_nxt;
   logic            r_tx_abort, w_abort_nxt;
   logic            r_od, w_od_nxt;
   logic            w_od_in;

`ifdef ONEWIRE_TX_OVERDRIVE_EN
   assign w_od_in = od_mode;
`else
   assign w_od_in = 1'b0;
`endif

   // r_od remembers the timing set chosen when the current sequence or slot began
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_shift_nxt  = r_shift;
      w_bitcnt_nxt = r_bitcnt;
      w_dq_nxt     = r_dq_oe;
      w_done_nxt   = 1'b0;
      w_abort_nxt  = 1'b0;
      w_od_nxt     = r_od;
      if (presence_req) begin
         w_state_nxt = PRES_WAIT;
         w_cnt_nxt   = w_od_in ? OD_PDH_LD : PDH_LD;
         w_od_nxt    = w_od_in;
         w_dq_nxt    = 1'b0;
         if (r_state == ARMED || r_state == BIT_SLOT) begin
            w_abort_nxt  = 1'b1;
            w_shift_nxt  = '0;
            w_bitcnt_nxt = '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               w_dq_nxt = 1'b0;
               if (tx_valid) begin
                  w_shift_nxt  = tx_data;
                  w_bitcnt_nxt = '0;
                  w_state_nxt  = ARMED;
               end
            end
            ARMED: begin
               if (slot_start) begin
                  w_state_nxt = BIT_SLOT;
                  w_cnt_nxt   = w_od_in ? OD_BIT0_LD : BIT0_LD;
                  w_od_nxt    = w_od_in;
                  w_dq_nxt    = ~r_shift[0];
               end
            end
            BIT_SLOT: begin
               if (r_cnt == '0) begin
                  w_dq_nxt     = 1'b0;
                  w_shift_nxt  = {1'b0, r_shift[7:1]};
                  w_bitcnt_nxt = r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = IDLE;
                  end else begin
                     w_state_nxt = ARMED;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            PRES_WAIT: begin
               if (r_cnt == '0) begin
                  w_state_nxt = PRES_LOW;
                  w_cnt_nxt   = r_od ? OD_PDL_LD : PDL_LD;
                  w_dq_nxt    = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            PRES_LOW: begin
               if (r_cnt == '0) begin
                  w_dq_nxt    = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_dq_nxt    = 1'b0;
            end
         endcase
      end
   end

   // state and output registers; reset releases DQ immediately
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_dq_oe     <= 1'b0;
         r_byte_done <= 1'b0;
         r_tx_abort  <= 1'b0;
         r_od        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_dq_oe     <= w_dq_nxt;
         r_byte_done <= w_done_nxt;
         r_tx_abort  <= w_abort_nxt;
         r_od        <= w_od_nxt;
      end
   end

   assign tx_ready  = (r_state == IDLE) & ~presence_req;
   assign busy      = (r_state != IDLE);
   assign dq_oe     = r_dq_oe;
   assign byte_done = r_byte_done;
   assign tx_abort  = r_tx_abort;

endmodule

// File: tb/tb_onewire_slave_tx.sv
// Bench for onewire_slave_tx: random bytes and presence requests, expected
// DQ edges and pulses queued with their cycle stamps from the timing rules.
module tb_onewire_slave_tx;
   localparam int PDH  = 30;
   localparam int PDL  = 120;
   localparam int BIT0 = 30;
   localparam int OPDH  = 3;
   localparam int OPDL  = 10;
   localparam int OBIT0 = 3;

   localparam int EV_RISE  = 1;
   localparam int EV_FALL  = 2;
   localparam int EV_DONE  = 3;
   localparam int EV_ABORT = 4;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic       slot_start = 1'b0;
   logic       presence_req = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
`ifdef ONEWIRE_TX_OVERDRIVE_EN
   logic       od_mode = 1'b0;
`endif
   logic       tx_ready, dq_oe, busy, byte_done, tx_abort;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_bad = 0;
   logic prev_dq = 1'b0;
   bit   mon_en = 1'b0;
   ev_t  exp_q[$];

   onewire_slave_tx #(
      .PDH_CYC (PDH),
      .PDL_CYC (PDL),
      .BIT0_CYC(BIT0)
   ) dut (
      .clk         (clk),
      .nRst        (nRst),
      .slot_start  (slot_start),
      .presence_req(presence_req),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
`ifdef ONEWIRE_TX_OVERDRIVE_EN
      .od_mode     (od_mode),
`endif
      .tx_ready    (tx_ready),
      .dq_oe       (dq_oe),
      .busy        (busy),
      .byte_done   (byte_done),
      .tx_abort    (tx_abort)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push(input int k, input int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      exp_q.push_back(e);
   endfunction

   task automatic handle(input int k);
      ev_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", k, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc) begin
            n_bad++;
            $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     k, cyc, e.kind, e.cyc);
         end
      end
   endtask

   // monitor: every DQ edge and every pulse must match the head of the queue
   always @(negedge clk) begin
      if (mon_en) begin
         if (dq_oe !== prev_dq) handle(dq_oe ? EV_RISE : EV_FALL);
         prev_dq = dq_oe;
         if (byte_done) handle(EV_DONE);
         if (tx_abort) handle(EV_ABORT);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_od(input bit od);
`ifdef ONEWIRE_TX_OVERDRIVE_EN
      od_mode = od;
`else
      if (od) $display("note: overdrive requested in a standard build");
`endif
   endtask

   task automatic pres(input bit od);
      int c;
      int ph, pl;
      ph = od ? OPDH : PDH;
      pl = od ? OPDL : PDL;
      c = cyc;
      set_od(od);
      presence_req = 1'b1;
      push(EV_RISE, c + ph + 1);
      push(EV_FALL, c + ph + 1 + pl);
      tick();
      presence_req = 1'b0;
      set_od(!od);
      repeat (ph + pl + 1) tick();
      set_od(1'b0);
      smp();
      check("pres_busy_end", busy, 0);
      check("pres_dq_end", dq_oe, 0);
      tick();
   endtask

   task automatic slot(input logic [7:0] b, input int i, input bit od, input int gap);
      int s;
      int bt;
      bt = od ? OBIT0 : BIT0;
      s = cyc;
      set_od(od);
      slot_start = 1'b1;
      if (!b[i]) begin
         push(EV_RISE, s + 1);
         push(EV_FALL, s + 1 + bt);
      end
      if (i == 7) push(EV_DONE, s + 1 + bt);
      tick();
      slot_start = 1'b0;
      set_od(!od);
      repeat (gap - 1) tick();
      set_od(1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int fixed_gap, input bit od);
      int bt;
      int g;
      bt = od ? OBIT0 : BIT0;
      tx_data  = b;
      tx_valid = 1'b1;
      smp();
      check("tx_ready_accept", tx_ready, 1);
      tick();
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) g = bt + 1;
         else if (fixed_gap != 0) g = fixed_gap;
         else g = $urandom_range(bt + 1, bt + 25);
         slot(b, i, od, g);
      end
      smp();
      check("tx_ready_after_byte", tx_ready, 1);
      check("busy_after_byte", busy, 0);
      tick();
   endtask

   initial begin
      logic [7:0] b;
      int k;
      int c;
      int j;

      // reset values, including tx_ready gated by presence_req
      presence_req = 1'b1;
      smp();
      check("rst_tx_ready_pres", tx_ready, 0);
      presence_req = 1'b0;
      smp();
      check("rst_dq_oe", dq_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_byte_done", byte_done, 0);
      check("rst_tx_abort", tx_abort, 0);
      check("rst_tx_ready", tx_ready, 1);
      tick();
      nRst = 1'b1;
      mon_en = 1'b1;
      repeat (3) tick();

      pres(1'b0);

      // slots with nothing loaded must be ignored
      for (int i = 0; i < 4; i++) begin
         slot_start = 1'b1;
         tick();
         slot_start = 1'b0;
         repeat ($urandom_range(2, 40)) tick();
         smp();
         check("idle_slot_busy", busy, 0);
         check("idle_slot_dq", dq_oe, 0);
         tick();
      end

      send_byte(8'hA5, 70, 1'b0);
      for (int n = 0; n < 6; n++) begin
         b = 8'($urandom);
         send_byte(b, 0, 1'b0);
         repeat ($urandom_range(0, 5)) tick();
      end

      // abort: 0x00, three slots, presence during the 4th slot's low phase
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      smp();
      check("abort_accept", tx_ready, 1);
      tick();
      tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) slot(8'h00, i, 1'b0, $urandom_range(BIT0 + 1, BIT0 + 20));
      k = $urandom_range(0, BIT0 - 1);
      slot_start = 1'b1;
      push(EV_RISE, cyc + 1);
      tick();
      slot_start = 1'b0;
      repeat (k) tick();
      smp();
      check("abort_dq_low_phase", dq_oe, 1);
      c = cyc;
      presence_req = 1'b1;
      push(EV_FALL, c + 1);
      push(EV_ABORT, c + 1);
      push(EV_RISE, c + PDH + 1);
      push(EV_FALL, c + PDH + 1 + PDL);
      tick();
      presence_req = 1'b0;
      repeat (PDH + PDL + 1) tick();
      smp();
      check("abort_busy_end", busy, 0);
      tick();

      // tx_valid and presence_req together: presence wins, byte refused
      c = cyc;
      tx_data = 8'h00;
      tx_valid = 1'b1;
      presence_req = 1'b1;
      smp();
      check("simul_tx_ready", tx_ready, 0);
      push(EV_RISE, c + PDH + 1);
      push(EV_FALL, c + PDH + 1 + PDL);
      tick();
      tx_valid = 1'b0;
      presence_req = 1'b0;
      repeat (PDH + PDL + 1) tick();
      slot_start = 1'b1;
      tick();
      slot_start = 1'b0;
      repeat (BIT0 + 3) tick();
      smp();
      check("simul_no_byte_busy", busy, 0);
      tick();

      // asynchronous reset in the middle of the presence low pulse
      c = cyc;
      presence_req = 1'b1;
      push(EV_RISE, c + PDH + 1);
      tick();
      presence_req = 1'b0;
      j = $urandom_range(2, PDL - 2);
      repeat (PDH + j) tick();
      smp();
      check("rst_mid_dq_before", dq_oe, 1);
      tick();
      push(EV_FALL, cyc);
      nRst = 1'b0;
      #1;
      check("rst_mid_dq_async", dq_oe, 0);
      check("rst_mid_busy", busy, 0);
      tick();
      tick();
      nRst = 1'b1;
      smp();
      check("rst_mid_tx_ready", tx_ready, 1);
      check("rst_mid_busy_after", busy, 0);
      tick();
      send_byte(8'($urandom), 0, 1'b0);

`ifdef ONEWIRE_TX_OVERDRIVE_EN
      pres(1'b1);
      send_byte(8'($urandom), 0, 1'b1);
      send_byte(8'h5A, 0, 1'b1);
      pres(1'b0);
`endif

      repeat (5) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
